// File: rtl/tri_bbox_scanner.sv
// tri_bbox_scanner
// Rasterizer scan stage. It accepts one triangle-setup record over a
// valid/ready handshake and walks the record's inclusive bounding box in
// raster order, evaluating one pixel per cycle. Three edge functions are
// stepped incrementally. Each covered pixel is emitted as a fragment (x,y)
// on a valid/ready output register.
//
// Optional feature macro: PIX_COUNT_EN adds the frag_cnt and tri_done
// outputs, which report the covered-pixel count of each finished triangle.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   vld_in / rdy_in    setup record handshake (rdy_in = IDLE && !rst)
//   xmin..ymax         inclusive bounding box
//   e0..e2             edge values at (xmin,ymin)
//   a0..a2, b0..b2     per-edge x / y steps
//   vld_out / rdy_out  fragment handshake
//   frag_x, frag_y     fragment coordinates
//   frag_cnt, tri_done covered count of last triangle and end pulse
//                      (PIX_COUNT_EN only)
module tri_bbox_scanner #(
  parameter int COORD_W = 11,
  parameter int EDGE_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vld_in,
  output logic                      rdy_in,
  input  logic [COORD_W-1:0]        xmin,
  input  logic [COORD_W-1:0]        xmax,
  input  logic [COORD_W-1:0]        ymin,
  input  logic [COORD_W-1:0]        ymax,
  input  logic signed [EDGE_W-1:0]  e0,
  input  logic signed [EDGE_W-1:0]  e1,
  input  logic signed [EDGE_W-1:0]  e2,
  input  logic signed [EDGE_W-1:0]  a0,
  input  logic signed [EDGE_W-1:0]  a1,
  input  logic signed [EDGE_W-1:0]  a2,
  input  logic signed [EDGE_W-1:0]  b0,
  input  logic signed [EDGE_W-1:0]  b1,
  input  logic signed [EDGE_W-1:0]  b2,
  output logic                      vld_out,
  input  logic                      rdy_out,
  output logic [COORD_W-1:0]        frag_x,
  output logic [COORD_W-1:0]        frag_y
`ifdef PIX_COUNT_EN
  ,
  output logic [2*COORD_W-1:0]      frag_cnt,
  output logic                      tri_done
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t state_q, state_d;

  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;

  logic signed [EDGE_W-1:0] e_q   [3];
  logic signed [EDGE_W-1:0] e_d   [3];
  logic signed [EDGE_W-1:0] row_q [3];
  logic signed [EDGE_W-1:0] row_d [3];
  logic signed [EDGE_W-1:0] a_q   [3];
  logic signed [EDGE_W-1:0] a_d   [3];
  logic signed [EDGE_W-1:0] b_q   [3];
  logic signed [EDGE_W-1:0] b_d   [3];

  logic               vld_q, vld_d;
  logic [COORD_W-1:0] fx_q, fx_d, fy_q, fy_d;

  logic accept, degenerate, slot_free, covered, last_px, advance;

  assign rdy_in     = (state_q == IDLE) && !rst;
  assign accept     = vld_in && rdy_in;
  assign degenerate = (xmin > xmax) || (ymin > ymax);
  assign slot_free  = !vld_q || rdy_out;
  assign advance    = (state_q == SCAN) && slot_free;
  assign last_px    = (cx_q == xmax_q) && (cy_q == ymax_q);
  // Covered when no edge is negative: all sign bits clear.
  assign covered    = !e_q[0][EDGE_W-1] && !e_q[1][EDGE_W-1] && !e_q[2][EDGE_W-1];

  // The output register is masked during reset so that a pending fragment
  // cannot be taken in the same cycle that discards it.
  assign vld_out = vld_q && !rst;
  assign frag_x  = fx_q;
  assign frag_y  = fy_q;

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    vld_d   = vld_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    for (int unsigned i = 0; i < 3; i++) begin
      e_d[i]   = e_q[i];
      row_d[i] = row_q[i];
      a_d[i]   = a_q[i];
      b_d[i]   = b_q[i];
    end

    case (state_q)
      IDLE: begin
        // A fragment left over from the previous triangle drains here.
        if (rdy_out) vld_d = 1'b0;
        if (accept && !degenerate) begin
          state_d = SCAN;
          xmin_d  = xmin;
          xmax_d  = xmax;
          ymax_d  = ymax;
          cx_d    = xmin;
          cy_d    = ymin;
          e_d[0]  = e0;  e_d[1]  = e1;  e_d[2]  = e2;
          row_d[0] = e0; row_d[1] = e1; row_d[2] = e2;
          a_d[0]  = a0;  a_d[1]  = a1;  a_d[2]  = a2;
          b_d[0]  = b0;  b_d[1]  = b1;  b_d[2]  = b2;
        end
      end
      SCAN: begin
        if (slot_free) begin
          vld_d = covered;
          if (covered) begin
            fx_d = cx_q;
            fy_d = cy_q;
          end
          if (last_px) begin
            state_d = IDLE;
          end else if (cx_q != xmax_q) begin
            cx_d = cx_q + 1'b1;
            for (int unsigned i = 0; i < 3; i++) e_d[i] = e_q[i] + a_q[i];
          end else begin
            cx_d = xmin_q;
            cy_d = cy_q + 1'b1;
            for (int unsigned i = 0; i < 3; i++) begin
              row_d[i] = row_q[i] + b_q[i];
              e_d[i]   = row_q[i] + b_q[i];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
      vld_q   <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        e_q[i]   <= '0;
        row_q[i] <= '0;
        a_q[i]   <= '0;
        b_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymax_q  <= ymax_d;
      vld_q   <= vld_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      for (int unsigned i = 0; i < 3; i++) begin
        e_q[i]   <= e_d[i];
        row_q[i] <= row_d[i];
        a_q[i]   <= a_d[i];
        b_q[i]   <= b_d[i];
      end
    end
  end

`ifdef PIX_COUNT_EN
  logic [2*COORD_W-1:0] cnt_q, cnt_d, fcnt_q, fcnt_d;
  logic                 done_q, done_d;

  assign frag_cnt = fcnt_q;
  assign tri_done = done_q;

  // accept only happens in IDLE and advance only in SCAN, so the two
  // branches never compete.
  always_comb begin
    cnt_d  = cnt_q;
    fcnt_d = fcnt_q;
    done_d = 1'b0;
    if (accept) begin
      cnt_d = '0;
      if (degenerate) begin
        fcnt_d = '0;
        done_d = 1'b1;
      end
    end else if (advance) begin
      if (covered) cnt_d = cnt_q + 1'b1;
      if (last_px) begin
        fcnt_d = covered ? cnt_q + 1'b1 : cnt_q;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      fcnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      done_q <= done_d;
    end
  end
`endif

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Testbench for tri_bbox_scanner: directed records, expected fragments
// queued at issue time and compared by an independent output monitor.
module tb_tri_bbox_scanner;

  localparam int CW = 11;
  localparam int EW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld_in = 1'b0;
  logic rdy_in;
  logic [CW-1:0] xmin = '0, xmax = '0, ymin = '0, ymax = '0;
  logic signed [EW-1:0] e0 = '0, e1 = '0, e2 = '0;
  logic signed [EW-1:0] a0 = '0, a1 = '0, a2 = '0;
  logic signed [EW-1:0] b0 = '0, b1 = '0, b2 = '0;
  logic vld_out;
  logic rdy_out = 1'b1;
  logic [CW-1:0] frag_x, frag_y;
`ifdef PIX_COUNT_EN
  logic [2*CW-1:0] frag_cnt;
  logic            tri_done;
`endif

  tri_bbox_scanner #(.COORD_W(CW), .EDGE_W(EW)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy_in),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
    .e0(e0), .e1(e1), .e2(e2), .a0(a0), .a1(a1), .a2(a2),
    .b0(b0), .b1(b1), .b2(b2),
    .vld_out(vld_out), .rdy_out(rdy_out), .frag_x(frag_x), .frag_y(frag_y)
`ifdef PIX_COUNT_EN
    , .frag_cnt(frag_cnt), .tri_done(tri_done)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int frags_seen = 0;
  logic [2*CW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*CW-1:0] xy(input int x, input int y);
    return {CW'(x), CW'(y)};
  endfunction

  // Output monitor: a fragment transfers at the next posedge when both
  // valid and ready are high mid-cycle.
  always @(negedge clk) begin
    if (vld_out && rdy_out) begin
      frags_seen++;
      if (exp_q.size() == 0) begin
        check("frag_unexpected_qsize", exp_q.size(), 1);
      end else begin
        logic [2*CW-1:0] e;
        e = exp_q.pop_front();
        check("frag_xy", {frag_x, frag_y}, e);
      end
    end
  end

  task automatic send(input int x0, input int x1, input int y0, input int y1,
                      input int ev0, input int ev1, input int ev2,
                      input int av0, input int av1, input int av2,
                      input int bv0, input int bv1, input int bv2);
    int n = 0;
    @(posedge clk); #1;
    xmin = CW'(x0); xmax = CW'(x1); ymin = CW'(y0); ymax = CW'(y1);
    e0 = ev0; e1 = ev1; e2 = ev2;
    a0 = av0; a1 = av1; a2 = av2;
    b0 = bv0; b1 = bv1; b2 = bv2;
    vld_in = 1'b1;
    @(negedge clk);
    while (!rdy_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_accept_timeout", n < 100, 1);
    @(posedge clk); #1;
    vld_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(rdy_in && !vld_out && exp_q.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_in_time"}, n < 300, 1);
    check({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld_out", vld_out, 0);
    check("rst_rdy_in", rdy_in, 0);
    check("rst_frag_x", frag_x, 0);
    check("rst_frag_y", frag_y, 0);
`ifdef PIX_COUNT_EN
    check("rst_frag_cnt", frag_cnt, 0);
    check("rst_tri_done", tri_done, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy_in", rdy_in, 1);

    // 1: 2x2 all covered, latency 2 cycles
    exp_q.push_back(xy(0, 0)); exp_q.push_back(xy(1, 0));
    exp_q.push_back(xy(0, 1)); exp_q.push_back(xy(1, 1));
    send(0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t1_vld_first_eval_cycle", vld_out, 0);
    @(negedge clk);
    check("t1_vld_two_after_accept", vld_out, 1);
    wait_idle("t1");
`ifdef PIX_COUNT_EN
    check("t1_frag_cnt", frag_cnt, 4);
`endif

    // 2: one row, edge0 goes negative after two pixels
    exp_q.push_back(xy(0, 0)); exp_q.push_back(xy(1, 0));
    send(0, 3, 0, 0, 1, 1, 1, -1, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("t2_busy_4th_eval", rdy_in, 0);
    @(negedge clk);
    check("t2_idle_after_4_evals", rdy_in, 1);
`ifdef PIX_COUNT_EN
    check("t2_tri_done", tri_done, 1);
    check("t2_frag_cnt", frag_cnt, 2);
    @(negedge clk);
    check("t2_tri_done_pulse_end", tri_done, 0);
`endif
    wait_idle("t2");

    // 3: stall while (1,0) is presented
    exp_q.push_back(xy(0, 0)); exp_q.push_back(xy(1, 0));
    exp_q.push_back(xy(0, 1)); exp_q.push_back(xy(1, 1));
    send(0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy_out = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_hold_vld", vld_out, 1);
      check("t3_hold_x", frag_x, 1);
      check("t3_hold_y", frag_y, 0);
    end
    @(posedge clk); #1;
    rdy_out = 1'b1;
    wait_idle("t3");

    // 4: degenerate record dropped, then a normal one
    send(5, 4, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t4_rdy_in_next", rdy_in, 1);
    check("t4_no_vld", vld_out, 0);
`ifdef PIX_COUNT_EN
    check("t4_tri_done", tri_done, 1);
    check("t4_frag_cnt", frag_cnt, 0);
`endif
    repeat (3) begin
      @(negedge clk);
      check("t4_still_no_vld", vld_out, 0);
    end
    send(0, 0, 3, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("t4_ydegen_rdy_in", rdy_in, 1);
    exp_q.push_back(xy(2, 3)); exp_q.push_back(xy(3, 3));
    send(2, 3, 3, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    wait_idle("t4");

    // Row stepping: E0 = x - 2y over 3x2 box
    exp_q.push_back(xy(0, 0)); exp_q.push_back(xy(1, 0));
    exp_q.push_back(xy(2, 0)); exp_q.push_back(xy(2, 1));
    send(0, 2, 0, 1, 0, 1, 1, 1, 0, 0, -2, 0, 0);
    wait_idle("trow");

    // Single pixel held, next record accepted while it drains
    rdy_out = 1'b0;
    exp_q.push_back(xy(1, 1)); exp_q.push_back(xy(2, 2));
    send(1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("tsp_pending_vld", vld_out, 1);
    check("tsp_idle_while_pending", rdy_in, 1);
    send(2, 2, 2, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      check("tsp_held_x", frag_x, 1);
    end
    @(posedge clk); #1;
    rdy_out = 1'b1;
    wait_idle("tsp");

    // 5: reset mid-scan of 4x4 all covered
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) exp_q.push_back(xy(x, y));
    send(0, 3, 0, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_vld_out", vld_out, 0);
    check("t5_rst_rdy_in", rdy_in, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    seen = frags_seen;
    repeat (20) @(negedge clk);
    check("t5_no_more_frags", frags_seen, seen);
    check("t5_idle_rdy_in", rdy_in, 1);
    check("t5_vld_out", vld_out, 0);
    check("t5_frag_x", frag_x, 0);
    check("t5_frag_y", frag_y, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
